// File: rtl/win_tile_sched.sv
// rtl/win_tile_sched.sv - Winograd F(2x2,3x3) tile scheduler: fetches 4x4 tiles at stride 2, registers engine results, streams 2x2 blocks out.
module win_tile_sched #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 19,
    parameter int COORD_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [7:0]                     mem_rd_data,
    output logic [127:0]                   win_img,
    input  logic signed [DATA_WIDTH-1:0]   win_result_0,
    input  logic signed [DATA_WIDTH-1:0]   win_result_1,
    input  logic signed [DATA_WIDTH-1:0]   win_result_2,
    input  logic signed [DATA_WIDTH-1:0]   win_result_3,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*DATA_WIDTH-1:0]        out_data,
    output logic [COORD_WIDTH-1:0]         out_row,
    output logic [COORD_WIDTH-1:0]         out_col
);

    localparam int TX = (IMG_W - 2) / 2;
    localparam int TY = (IMG_H - 2) / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_COMPUTE,
        S_OUT,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                k_q, k_d;
    logic [COORD_WIDTH-1:0]    tx_q, tx_d;
    logic [COORD_WIDTH-1:0]    ty_q, ty_d;
    logic                      rd_pend_q, rd_pend_d;
    logic [3:0]                rd_k_q, rd_k_d;
    logic [127:0]              win_q, win_d;
    logic [4*DATA_WIDTH-1:0]   data_q, data_d;
    logic [COORD_WIDTH-1:0]    row_q, row_d;
    logic [COORD_WIDTH-1:0]    col_q, col_d;

    logic                      last_tile;
    logic                      last_col;
    logic [ADDR_WIDTH-1:0]     row_a;
    logic [ADDR_WIDTH-1:0]     col_a;

    assign last_col  = (tx_q == COORD_WIDTH'(TX - 1));
    assign last_tile = last_col && (ty_q == COORD_WIDTH'(TY - 1));

    // Tile origin is (2*ty, 2*tx); k walks the 4x4 window row-major.
    assign row_a = ADDR_WIDTH'({ty_q, 1'b0}) + ADDR_WIDTH'(k_q[3:2]);
    assign col_a = ADDR_WIDTH'({tx_q, 1'b0}) + ADDR_WIDTH'(k_q[1:0]);

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        rd_pend_d = 1'b0;
        rd_k_d    = k_q;
        win_d     = win_q;
        data_d    = data_q;
        row_d     = row_q;
        col_d     = col_q;

        // Read data lags its strobe by one cycle; drop it into the slot it was issued for.
        if (rd_pend_q) begin
            for (int i = 0; i < 16; i++) begin
                if (rd_k_q == 4'(i)) begin
                    win_d[127 - 8*i -: 8] = mem_rd_data;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    tx_d    = '0;
                    ty_d    = '0;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                rd_pend_d = 1'b1;
                k_d       = k_q + 4'd1;
                if (k_q == 4'd15) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                data_d  = {win_result_3, win_result_2, win_result_1, win_result_0};
                row_d   = {ty_q[COORD_WIDTH-2:0], 1'b0};
                col_d   = {tx_q[COORD_WIDTH-2:0], 1'b0};
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_tile) begin
                        state_d = S_DONE;
                    end else begin
                        if (last_col) begin
                            tx_d = '0;
                            ty_d = ty_q + 1'b1;
                        end else begin
                            tx_d = tx_q + 1'b1;
                        end
                        k_d     = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            tx_q      <= '0;
            ty_q      <= '0;
            rd_pend_q <= 1'b0;
            rd_k_q    <= '0;
            win_q     <= '0;
            data_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            tx_q      <= tx_d;
            ty_q      <= ty_d;
            rd_pend_q <= rd_pend_d;
            rd_k_q    <= rd_k_d;
            win_q     <= win_d;
            data_q    <= data_d;
            row_q     <= row_d;
            col_q     <= col_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign mem_rd_en = (state_q == S_FETCH);
    assign mem_addr  = (state_q == S_FETCH) ? (row_a * ADDR_WIDTH'(IMG_W) + col_a) : '0;
    assign win_img   = win_q;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;

endmodule

// File: doc/win_tile_sched.md
Name: win_tile_sched

Overview:
- Tile scheduler and sequencer for the Winograd F(2x2,3x3) engine (combinational, 4x4 int8 tile in, four signed 2x2 results out).
- Walks an IMG_W x IMG_H int8 feature map held in a byte-wide synchronous-read memory, in 4x4 input tiles at stride 2.
- Assembles each tile, presents it to the engine, and registers the four results.
- Emits one 2x2 output block per tile to a downstream writer over a valid/ready handshake, tagged with output coordinates.

Parameters:
- IMG_W, 8, feature-map width in pixels; even, >=4.
- IMG_H, 8, feature-map height in pixels; even, >=4.
- ADDR_WIDTH, 12, memory byte-address width; IMG_W*IMG_H <= 2**ADDR_WIDTH.
- DATA_WIDTH, 19, width of each signed engine result.
- COORD_WIDTH, 8, width of output row/col coordinates.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a full-map pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last tile's output handshake.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_WIDTH  byte address, pixel (row,col) = row*IMG_W+col.
- mem_rd_data  in  8  pixel byte, valid the cycle after mem_rd_en.
- win_img  out  128  tile to engine; pixel k=r*4+c at bits [127-8k -: 8] (k=0 in MSB byte).
- win_result_0..3  in  DATA_WIDTH each, signed; engine outputs, combinational from win_img.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accept.
- out_data  out  4*DATA_WIDTH  {result_3,result_2,result_1,result_0}, result_0 in LSBs.
- out_row, out_col  out  COORD_WIDTH each  top-left output coordinate = 2*ty, 2*tx.

Behaviour:
- Reset: state IDLE; busy, done, mem_rd_en, out_valid = 0; mem_addr, win_img, out_data, out_row, out_col, tile counters = 0.
- Reset mid-operation: aborts immediately; no done pulse; any pending output is dropped.
- Tile grid: TX=(IMG_W-2)/2, TY=(IMG_H-2)/2. Raster order; tx increments fastest, wraps to 0 with ty+1.
- States:
  - IDLE: start=1 -> FETCH with tx=ty=0, k=0. Otherwise stay.
  - FETCH: mem_rd_en=1, mem_addr=(2*ty+k/4)*IMG_W+2*tx+k%4. k increments each cycle; after k=15 -> WAIT.
  - WAIT: single cycle; mem_rd_en=0; captures the byte for k=15.
  - COMPUTE: single cycle; win_img stable; win_result_0..3 and coordinates registered at end of cycle -> OUT.
  - OUT: out_valid=1. On out_valid&&out_ready: if last tile (tx=TX-1, ty=TY-1) -> DONE, else advance tx/ty -> FETCH.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Byte capture: the byte returned in cycle n+1 for read k (issued in cycle n) is written into win_img slot k at the end of cycle n+1. win_img holds its value from end of WAIT until overwritten in the next FETCH.
- Latency:
  - Start sampled in cycle 0; mem_rd_en high in cycles 1-16; WAIT in 17; COMPUTE in 18; out_valid first high in cycle 19.
  - Per tile with out_ready held high: 19 cycles, handshake to the next tile's first read = 1 cycle.
- Backpressure: while out_valid && !out_ready, out_data, out_row, out_col stay stable and no memory reads are issued.
- start while busy: ignored, no restart. start in the same cycle as the done pulse: ignored.
- Arithmetic: results are passed through bit-exact; no saturation or extension inside the block.

Test Plan:
- IMG_W=IMG_H=6, mem[a]=a, start pulse -> tile (0,0) reads addresses 0,1,2,3,6,7,8,9,12,13,14,15,18,19,20,21 in cycles 1-16; win_img at COMPUTE = 128'h00010203_06070809_0C0D0E0F_12131415.
- Same map, tile (tx=1,ty=0) -> addresses 2,3,4,5,8,9,10,11,14,15,16,17,20,21,22,23; out_row=0, out_col=2.
- Stub engine drives results -5, 7, -262144, 262143 with out_ready=1 -> out_data fields match exactly with sign preserved; 4 handshakes; done pulses once in cycle 77; busy low afterwards.
- out_ready held low 5 cycles on tile 0 -> out_valid stays high; out_data, out_row, out_col are unchanged; mem_rd_en=0 throughout; the next reads start the cycle after the handshake.
- rst asserted during FETCH at k=7 -> next cycle IDLE, all outputs 0, no done. A fresh start then restarts at address 0.
- start pulsed during FETCH and during OUT -> no effect; sequence and done timing are identical to the single-start run.
